gelu_lut_loader: RTL and testbench
==================================

Name: gelu_lut_loader

Overview:
- Writer-side companion to the GELU dual-port segment LUT (ADDR_WIDTH=4, DATA_WIDTH=20, registered read, async active-low reset).
- Accepts a valid/ready stream of LUT entries and writes them sequentially into table port A.
- Optionally reads the table back through port B and compares checksums, so the table can be reprogrammed at runtime instead of relying only on file preload.
- Sits between the configuration CSR/stream path and the LUT; the GELU datapath must not issue lookups while busy=1.

Parameters:
- ADDR_WIDTH, 4, LUT address width; depth = 1<<ADDR_WIDTH.
- DATA_WIDTH, 20, LUT entry width.
- CSUM_WIDTH, DATA_WIDTH+ADDR_WIDTH, width of the additive checksum accumulator.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load. Ignored unless state is IDLE, DONE or ERR.
- verify_en  in  1  sampled on the accepted start; 1 means run a readback pass after loading.
- s_data  in  DATA_WIDTH  incoming LUT entry.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- ram_addr_a  out  ADDR_WIDTH  write address to LUT port A.
- ram_data_a  out  DATA_WIDTH  write data to LUT port A.
- ram_we_a  out  1  write enable to LUT port A.
- ram_addr_b  out  ADDR_WIDTH  readback address to LUT port B.
- ram_q_b  in  DATA_WIDTH  LUT port B registered read data.
- busy  out  1  load or verify in progress.
- done  out  1  sticky; load (and verify, if enabled) completed successfully.
- err  out  1  sticky; verify checksum mismatch.

Behaviour:
- Reset values: state=IDLE; s_ready=0, ram_we_a=0, ram_addr_a=0, ram_data_a=0, ram_addr_b=0, busy=0, done=0, err=0; counters and checksums=0. Reset acts asynchronously and at any point, including mid-load; there is no partial-load recovery.
- All outputs are registered except s_ready, which is a combinational decode of state (s_ready = state==LOAD).
- States and transitions:
  - IDLE/DONE/ERR: on start, clear done, err, wr_cnt, csum_wr and csum_rd; latch verify_en; go to LOAD.
  - LOAD:
    - Each handshake (s_valid && s_ready) registers ram_we_a=1, ram_addr_a=wr_cnt, ram_data_a=s_data on the next edge, adds s_data to csum_wr (mod 2^CSUM_WIDTH), and increments wr_cnt.
    - ram_we_a is 0 on any cycle without a handshake on the previous edge.
    - After the handshake for entry depth-1: go to DRAIN for one cycle so the final write lands.
  - DRAIN: ram_we_a=0. If verify is latched, go to VERIFY with rd_cnt=0; otherwise go to DONE and set done=1.
  - VERIFY:
    - Drive ram_addr_b=rd_cnt and increment rd_cnt every cycle for depth cycles.
    - Data returns one cycle after its address. Track this with a 1-bit rd_vld pipeline flag and add ram_q_b to csum_rd when rd_vld=1.
    - After the final returned word, compare in state CHECK.
  - CHECK: csum_rd==csum_wr sets done=1 and goes to DONE; otherwise sets err=1 and goes to ERR.
- busy=1 in LOAD, DRAIN, VERIFY and CHECK.
- Latency: with s_valid held high, a load takes depth+1 cycles (16 accepts plus 1 drain). Verify adds depth+2 cycles.
- Boundaries:
  - wr_cnt and rd_cnt are ADDR_WIDTH+1 bits wide, so terminal count is detected without address wrap. ram_addr_a and ram_addr_b use the low bits only.
  - s_valid deasserting mid-load stalls with no write and no counter change; this is legal indefinitely.
  - start while busy is ignored, and no counters are disturbed.
  - start in the same cycle as the DONE transition is ignored; it is only honoured once state is DONE.
  - Port B is never read at an address in the same cycle that address is written, because of the DRAIN ordering.

Decomposition:
- Shared package gelu_lut_pkg holds: the state enum (IDLE, LOAD, DRAIN, VERIFY, CHECK, DONE, ERR), LUT_ADDR_WIDTH=4, LUT_DATA_WIDTH=20, and the derived LUT_DEPTH.
- One natural sub-module: gelu_lut_csum, an accumulator with clear, enable and data inputs.
  - Two instances: write side and read side.
  - The same module is reusable by other LUT loaders in the FPU.

Test Plan:
- Continuous load, verify_en=0: stream entries 0x00001..0x00010 with s_valid held high. Required: 16 writes at addresses 0..15 on consecutive cycles; done=1 at cycle 17 after start; err=0; the LUT model holds the values.
- Bubbled stream: s_valid toggles 1,0,1,0 during load. Required: ram_we_a only follows handshakes; addresses stay contiguous; done after exactly 16 writes.
- Verify pass with the real LUT: load 0xFFFFF in all entries with verify_en=1. Required: csum_wr=csum_rd=0xFFFFF0; done=1 and err=0 after 16+1+16+2 cycles.
- Verify mismatch: force LUT entry 5 to 0x00000 after its write. Required: err=1, done=0, state ERR, busy=0.
- Reset mid-load: assert rst_n=0 after 7 writes. Required: all outputs 0 immediately (asynchronously). A new start then reloads from address 0.
- Start while busy: pulse start at write 3. Required: no effect; the load completes normally with done=1.

Source files
------------

// File: rtl/gelu_lut_pkg.sv
// Shared definitions for the GELU segment LUT and its runtime loader.
package gelu_lut_pkg;

   localparam int LUT_ADDR_WIDTH = 4;
   localparam int LUT_DATA_WIDTH = 20;
   localparam int LUT_DEPTH      = 1 << LUT_ADDR_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DRAIN,
      VERIFY,
      CHECK,
      DONE,
      ERR
   } lut_ld_state_e;

endpackage

// File: rtl/gelu_lut_csum.sv
// Additive checksum accumulator (modulo 2^CSUM_WIDTH) with synchronous clear.
module gelu_lut_csum
   import gelu_lut_pkg::*;
#(
   parameter int DATA_WIDTH = LUT_DATA_WIDTH,
   parameter int CSUM_WIDTH = LUT_DATA_WIDTH + LUT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [CSUM_WIDTH-1:0] sum_o
);

   logic [CSUM_WIDTH-1:0] sum_q;
   logic [CSUM_WIDTH-1:0] sum_d;

   // Clear wins over accumulate so a restart never folds in a stale word.
   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = '0;
      end else if (en_i) begin
         sum_d = sum_q + CSUM_WIDTH'(data_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/gelu_lut_loader.sv
// Streams LUT entries into the GELU segment table (port A) and optionally
// reads them back through port B, comparing additive checksums.
module gelu_lut_loader
   import gelu_lut_pkg::*;
#(
   parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
   parameter int DATA_WIDTH = LUT_DATA_WIDTH,
   parameter int CSUM_WIDTH = DATA_WIDTH + ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  verify_en,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] ram_addr_a,
   output logic [DATA_WIDTH-1:0] ram_data_a,
   output logic                  ram_we_a,
   output logic [ADDR_WIDTH-1:0] ram_addr_b,
   input  logic [DATA_WIDTH-1:0] ram_q_b,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   // Counters carry one extra bit so the terminal count never aliases address 0.
   localparam logic [ADDR_WIDTH:0] CNT_LAST  = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0] CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   lut_ld_state_e           state_q;
   logic [ADDR_WIDTH:0]     wr_cnt_q;
   logic [ADDR_WIDTH:0]     rd_cnt_q;
   logic [ADDR_WIDTH:0]     wr_cnt_d;
   logic [ADDR_WIDTH:0]     rd_cnt_d;
   logic                    verify_q;
   logic                    rd_vld_q;
   logic                    we_a_q;
   logic [ADDR_WIDTH-1:0]   addr_a_q;
   logic [DATA_WIDTH-1:0]   data_a_q;
   logic [ADDR_WIDTH-1:0]   addr_b_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    err_q;

   logic                    start_ok;
   logic                    handshake;
   logic                    rd_acc;
   logic [CSUM_WIDTH-1:0]   csum_wr;
   logic [CSUM_WIDTH-1:0]   csum_rd;

   assign s_ready   = (state_q == LOAD);
   assign handshake = s_valid && s_ready;
   assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
   assign rd_acc    = rd_vld_q && (state_q == VERIFY);
   assign wr_cnt_d  = wr_cnt_q + 1'b1;
   assign rd_cnt_d  = rd_cnt_q + 1'b1;

   gelu_lut_csum #(
      .DATA_WIDTH (DATA_WIDTH),
      .CSUM_WIDTH (CSUM_WIDTH)
   ) u_csum_wr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (start_ok),
      .en_i   (handshake),
      .data_i (s_data),
      .sum_o  (csum_wr)
   );

   gelu_lut_csum #(
      .DATA_WIDTH (DATA_WIDTH),
      .CSUM_WIDTH (CSUM_WIDTH)
   ) u_csum_rd (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (start_ok),
      .en_i   (rd_acc),
      .data_i (ram_q_b),
      .sum_o  (csum_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         verify_q <= 1'b0;
         rd_vld_q <= 1'b0;
         we_a_q   <= 1'b0;
         addr_a_q <= '0;
         data_a_q <= '0;
         addr_b_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         we_a_q <= 1'b0;
         case (state_q)
            IDLE, DONE, ERR: begin
               if (start) begin
                  done_q   <= 1'b0;
                  err_q    <= 1'b0;
                  wr_cnt_q <= '0;
                  rd_cnt_q <= '0;
                  rd_vld_q <= 1'b0;
                  verify_q <= verify_en;
                  busy_q   <= 1'b1;
                  state_q  <= LOAD;
               end
            end
            LOAD: begin
               if (s_valid) begin
                  we_a_q   <= 1'b1;
                  addr_a_q <= wr_cnt_q[ADDR_WIDTH-1:0];
                  data_a_q <= s_data;
                  wr_cnt_q <= wr_cnt_d;
                  if (wr_cnt_q == CNT_LAST) begin
                     state_q <= DRAIN;
                  end
               end
            end
            // The last write lands during DRAIN, so readback never races it.
            DRAIN: begin
               if (verify_q) begin
                  rd_cnt_q <= '0;
                  rd_vld_q <= 1'b0;
                  addr_b_q <= '0;
                  state_q  <= VERIFY;
               end else begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            VERIFY: begin
               if (rd_cnt_q != CNT_DEPTH) begin
                  rd_vld_q <= 1'b1;
                  rd_cnt_q <= rd_cnt_d;
                  addr_b_q <= rd_cnt_d[ADDR_WIDTH-1:0];
               end else begin
                  rd_vld_q <= 1'b0;
                  state_q  <= CHECK;
               end
            end
            CHECK: begin
               busy_q <= 1'b0;
               if (csum_rd == csum_wr) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  err_q   <= 1'b1;
                  state_q <= ERR;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ram_we_a   = we_a_q;
   assign ram_addr_a = addr_a_q;
   assign ram_data_a = data_a_q;
   assign ram_addr_b = addr_b_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_gelu_lut_loader.sv
// Directed bench for gelu_lut_loader with a registered-read dual-port LUT model.
module tb_gelu_lut_loader;

   localparam int AW    = 4;
   localparam int DW    = 20;
   localparam int CW    = 24;
   localparam int DEPTH = gelu_lut_pkg::LUT_DEPTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          verify_en = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [AW-1:0] ram_addr_a;
   logic [DW-1:0] ram_data_a;
   logic          ram_we_a;
   logic [AW-1:0] ram_addr_b;
   logic [DW-1:0] ram_q_b;
   logic          busy;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   gelu_lut_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .verify_en  (verify_en),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .ram_addr_a (ram_addr_a),
      .ram_data_a (ram_data_a),
      .ram_we_a   (ram_we_a),
      .ram_addr_b (ram_addr_b),
      .ram_q_b    (ram_q_b),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // LUT model; corrupt_en makes entry 5 read back as zero.
   logic [DW-1:0] mem [DEPTH];
   logic          corrupt_en = 1'b0;

   always_ff @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
      ram_q_b <= (corrupt_en && (ram_addr_b == 4'd5)) ? '0 : mem[ram_addr_b];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] entry(input logic [DW-1:0] b, input logic [DW-1:0] s, input int i);
      logic [DW-1:0] ii;
      ii = DW'(i);
      return b + s * ii;
   endfunction

   // Write monitor: logs every port-A write and checks it follows a handshake.
   int            wr_n = 0;
   logic [AW-1:0] wr_addr_log [512];
   logic [DW-1:0] wr_data_log [512];
   logic          hs_prev = 1'b0;
   logic          mon_en = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mon_en) chk("we_follows_hs", 32'(ram_we_a), 32'(hs_prev));
            hs_prev = s_valid && s_ready;
            if (ram_we_a && wr_n < 512) begin
               wr_addr_log[wr_n] = ram_addr_a;
               wr_data_log[wr_n] = ram_data_a;
               wr_n++;
            end
         end else begin
            hs_prev = 1'b0;
         end
      end
   end

   task automatic run_load(input logic ver, input logic [DW-1:0] base, input logic [DW-1:0] step,
                           input logic bubble, input int glitch_k, output int cycles);
      int   idx;
      int   k;
      logic hs;
      idx = 0;
      verify_en = ver;
      start = 1'b1;
      s_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      verify_en = 1'b0;
      cycles = 0;
      while (!(done || err) && cycles < 200) begin
         k = cycles + 1;
         s_valid = (idx < DEPTH) && (!bubble || k[0]);
         s_data = entry(base, step, idx);
         if (k == glitch_k) begin
            start = 1'b1;
            verify_en = 1'b1;
         end
         hs = s_valid && s_ready;
         @(posedge clk); #1;
         start = 1'b0;
         verify_en = 1'b0;
         if (hs) idx++;
         cycles++;
      end
      s_valid = 1'b0;
   endtask

   task automatic check_writes(input int n0, input logic [DW-1:0] base, input logic [DW-1:0] step);
      chk("write_count", 32'(wr_n - n0), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         chk("wr_addr", 32'(wr_addr_log[n0 + i]), 32'(i));
         chk("wr_data", 32'(wr_data_log[n0 + i]), 32'(entry(base, step, i)));
         chk("lut_mem", 32'(mem[i]), 32'(entry(base, step, i)));
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_we_a", 32'(ram_we_a), 32'd0);
      chk("rst_addr_a", 32'(ram_addr_a), 32'd0);
      chk("rst_data_a", 32'(ram_data_a), 32'd0);
      chk("rst_addr_b", 32'(ram_addr_b), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
   endtask

   typedef struct {
      logic          verify;
      logic [DW-1:0] base;
      logic [DW-1:0] step;
      logic          bubble;
      logic          corrupt;
      logic          exp_done;
      logic          exp_err;
      int            exp_cycles;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int            cyc;
      int            n0;
      logic [CW-1:0] sum_wr;
      logic [CW-1:0] sum_rd;

      vecs[0] = '{1'b0, 20'h00001, 20'h00001, 1'b0, 1'b0, 1'b1, 1'b0, 17};
      vecs[1] = '{1'b0, 20'h80000, 20'h01111, 1'b1, 1'b0, 1'b1, 1'b0, 32};
      vecs[2] = '{1'b1, 20'hFFFFF, 20'h00000, 1'b0, 1'b0, 1'b1, 1'b0, 35};
      vecs[3] = '{1'b1, 20'h12345, 20'h00101, 1'b0, 1'b1, 1'b0, 1'b1, 35};
      vecs[4] = '{1'b1, 20'hABCDE, 20'h0F0F0, 1'b1, 1'b0, 1'b1, 1'b0, 50};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 5; v++) begin
         corrupt_en = vecs[v].corrupt;
         n0 = wr_n;
         run_load(vecs[v].verify, vecs[v].base, vecs[v].step, vecs[v].bubble, -1, cyc);
         chk("cycles", 32'(cyc), 32'(vecs[v].exp_cycles));
         chk("done", 32'(done), 32'(vecs[v].exp_done));
         chk("err", 32'(err), 32'(vecs[v].exp_err));
         chk("busy_end", 32'(busy), 32'd0);
         chk("s_ready_end", 32'(s_ready), 32'd0);
         chk("state", 32'(dut.state_q),
             vecs[v].exp_err ? 32'(gelu_lut_pkg::ERR) : 32'(gelu_lut_pkg::DONE));
         check_writes(n0, vecs[v].base, vecs[v].step);
         sum_wr = '0;
         sum_rd = '0;
         for (int i = 0; i < DEPTH; i++) begin
            sum_wr = sum_wr + CW'(entry(vecs[v].base, vecs[v].step, i));
            if (!(vecs[v].corrupt && i == 5)) sum_rd = sum_rd + CW'(entry(vecs[v].base, vecs[v].step, i));
         end
         if (!vecs[v].verify) sum_rd = '0;
         chk("csum_wr", 32'(dut.csum_wr), 32'(sum_wr));
         chk("csum_rd", 32'(dut.csum_rd), 32'(sum_rd));
         corrupt_en = 1'b0;
         @(posedge clk); #1;
      end

      // start while busy: ignored, verify_en of the stray pulse not latched
      n0 = wr_n;
      run_load(1'b0, 20'h00010, 20'h00003, 1'b0, 3, cyc);
      chk("busy_start_cycles", 32'(cyc), 32'd17);
      chk("busy_start_done", 32'(done), 32'd1);
      chk("busy_start_err", 32'(err), 32'd0);
      chk("busy_start_csum_rd", 32'(dut.csum_rd), 32'd0);
      check_writes(n0, 20'h00010, 20'h00003);

      // start coinciding with the DRAIN->DONE edge is dropped
      run_load(1'b0, 20'h00200, 20'h00020, 1'b0, 17, cyc);
      chk("late_start_cycles", 32'(cyc), 32'd17);
      repeat (2) @(posedge clk);
      #1;
      chk("late_start_done", 32'(done), 32'd1);
      chk("late_start_busy", 32'(busy), 32'd0);
      chk("late_start_ready", 32'(s_ready), 32'd0);

      // asynchronous reset after 7 writes, then a clean reload from address 0
      verify_en = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j < 7; j++) begin
         s_valid = 1'b1;
         s_data = entry(20'h77777, 20'h00001, j);
         @(posedge clk); #1;
      end
      chk("pre_reset_we", 32'(ram_we_a), 32'd1);
      chk("pre_reset_addr", 32'(ram_addr_a), 32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      s_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n0 = wr_n;
      run_load(1'b0, 20'h55555, 20'h11111, 1'b0, -1, cyc);
      chk("reload_cycles", 32'(cyc), 32'd17);
      chk("reload_done", 32'(done), 32'd1);
      check_writes(n0, 20'h55555, 20'h11111);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
